// File: rtl/weight_reader.sv
// Read-side sequencer for the per-layer weight memory: walks rows, captures each row, and hands it downstream over valid/ready.
// Define WEIGHT_READER_LOOP_EN to wrap back to layer 0 after the last vector instead of finishing the pass.
module weight_reader #(
  parameter int LAYER_SIZE  = 4,
  parameter int LAYER_DEPTH = 4,
  parameter int BIT_SIZE    = 16,
  localparam int AW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1,
  localparam int DW = LAYER_SIZE * BIT_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_layer,
  input  logic [DW-1:0] mem_w,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [DW-1:0] w_data,
  output logic [AW-1:0] w_layer,
  output logic          w_last
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, PRESENT, FIN} state_t;

  localparam logic [AW-1:0] LAST_LAYER = AW'(LAYER_DEPTH - 1);

  state_t state;

  // mem_layer doubles as the layer counter: it always equals the row being fetched or presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_layer <= '0;
      w_valid   <= 1'b0;
      w_data    <= '0;
      w_layer   <= '0;
      w_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        w_valid   <= 1'b0;
        w_last    <= 1'b0;
        mem_layer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= ADDR;
              busy      <= 1'b1;
              mem_layer <= '0;
            end
          end
          ADDR: state <= WAIT;
          WAIT: begin
            w_data  <= mem_w;
            w_layer <= mem_layer;
            w_last  <= (mem_layer == LAST_LAYER);
            w_valid <= 1'b1;
            state   <= PRESENT;
          end
          PRESENT: begin
            if (w_ready) begin
              w_valid <= 1'b0;
              w_last  <= 1'b0;
              if (mem_layer != LAST_LAYER) begin
                mem_layer <= mem_layer + AW'(1);
                state     <= ADDR;
              end else begin
`ifdef WEIGHT_READER_LOOP_EN
                mem_layer <= '0;
                done      <= 1'b1;
                state     <= ADDR;
`else
                done  <= 1'b1;
                state <= FIN;
`endif
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_reader.sv
// Scoreboard bench for weight_reader: stimulus pushes expected vectors, a monitor pops them on each handshake.
module tb_weight_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  mem_layer;
  logic [63:0] mem_w;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [1:0]  w_layer;
  logic        w_last;

  always #5 clk = ~clk;

  weight_reader #(.LAYER_SIZE(4), .LAYER_DEPTH(4), .BIT_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_layer(mem_layer), .mem_w(mem_w), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_layer(w_layer), .w_last(w_last)
  );

  // Memory model: row L node n holds 16*L+n, node 0 in the LSBs, one-cycle read latency.
  logic [63:0] mem [4];
  initial begin
    for (int l = 0; l < 4; l++)
      for (int n = 0; n < 4; n++)
        mem[l][n*16 +: 16] = 16'(16 * l + n);
  end
  always @(posedge clk) mem_w <= mem[mem_layer];

  typedef struct {
    logic [1:0]  layer;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] exp_row(input int l);
    logic [63:0] r;
    for (int n = 0; n < 4; n++) r[n*16 +: 16] = 16'(16 * l + n);
    return r;
  endfunction

  task automatic push_layers(input int first, input int last);
    exp_t e;
    for (int l = first; l <= last; l++) begin
      e.layer = 2'(l);
      e.data  = exp_row(l);
      e.last  = (l == 3);
      sb.push_back(e);
    end
  endtask

  // Monitor: a vector is consumed at the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) done_cnt++;
    if (rst && w_valid && w_ready) begin
      acc_cnt++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got layer %0d expected no vector", w_layer);
      end else begin
        e = sb.pop_front();
        chk("w_layer", 64'(w_layer), 64'(e.layer));
        chk("w_data", w_data, e.data);
        chk("w_last", 64'(w_last), 64'(e.last));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_layer(input int l);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (w_valid && w_layer == 2'(l)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_layer", 64'(ok), 64'd1);
  endtask

  task automatic run_idle;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) break;
    end
    chk("pass_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid_last", {w_valid, w_last}, 64'd0);
    chk("rst_layers", {mem_layer, w_layer}, 64'd0);
    chk("rst_data", w_data, 64'd0);
    rst = 1'b1;
    tick();

    // start together with abort in IDLE does nothing
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'd0);
    tick();

`ifdef WEIGHT_READER_LOOP_EN
    begin
      int base;
      bit busy_dropped = 1'b0;
      w_ready = 1'b1;
      push_layers(0, 3); push_layers(0, 3); push_layers(0, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      base = acc_cnt;
      d0 = done_cnt;
      for (int i = 0; i < 100; i++) begin
        if (acc_cnt >= base + 10) break;
        tick();
        if (!busy) busy_dropped = 1'b1;
      end
      chk("loop_accepts", 64'(acc_cnt - base), 64'd10);
      chk("loop_busy_held", 64'(busy_dropped), 64'd0);
      chk("loop_done_wraps", 64'(done_cnt - d0), 64'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("loop_abort_busy", 64'(busy), 64'd0);
      chk("loop_abort_valid", 64'(w_valid), 64'd0);
      chk("loop_abort_layer", 64'(mem_layer), 64'd0);
      sb.delete();
    end
`else
    // Full pass with w_ready held high: latency and pass completion
    w_ready = 1'b1;
    push_layers(0, 3);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_valid_e1", 64'(w_valid), 64'd0);
    tick();
    chk("lat_valid_e2", 64'(w_valid), 64'd0);
    tick();
    chk("lat_valid_e3", 64'(w_valid), 64'd1);
    chk("lat_layer0", 64'(w_layer), 64'd0);
    run_idle();
    chk("pass1_done", 64'(done_cnt - d0), 64'd1);
    tick();
    chk("pass1_idle_valid", 64'(w_valid), 64'd0);

    // Backpressure on layer 1
    push_layers(0, 3);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_layer(1);
    w_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {w_valid, w_last, w_layer, mem_layer}, {58'd0, 1'b1, 1'b0, 2'd1, 2'd1});
      chk("bp_data", w_data, 64'h0013_0012_0011_0010);
    end
    w_ready = 1'b1;
    run_idle();
    chk("bp_done", 64'(done_cnt - d0), 64'd1);
    tick();

    // start pulsed during PRESENT of layer 2 is ignored
    push_layers(0, 3);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_layer(2);
    chk("row2_data", w_data, 64'h0023_0022_0021_0020);
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    run_idle();
    chk("ign_start_done", 64'(done_cnt - d0), 64'd1);
    tick(); tick();
    chk("ign_start_idle", 64'(busy), 64'd0);

    // abort in WAIT of layer 1
    push_layers(0, 0);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_layer(0);
    tick();
    tick();
    chk("wait_l1_addr", {w_valid, mem_layer}, {61'd0, 1'b0, 2'd1});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(w_valid), 64'd0);
    chk("abort_mem_layer", 64'(mem_layer), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_stays_idle", {busy, w_valid}, 64'd0);
    push_layers(0, 3);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_idle();
    chk("post_abort_done", 64'(done_cnt - d0), 64'd1);
    tick();

    // Async reset while layer 0 is presented under backpressure
    w_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_layer(0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctrl", {busy, done, w_valid, w_last}, 64'd0);
    chk("arst_layers", {mem_layer, w_layer}, 64'd0);
    chk("arst_data", w_data, 64'd0);
    tick();
    rst = 1'b1;
    w_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_idle", {busy, w_valid}, 64'd0);
    end
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    push_layers(0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_idle();
    chk("arst_pass_done", 64'(done_cnt - d0), 64'd1);
`endif

    tick(); tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
